// File: rtl/cacheline_adapter_if.sv
// Bundles the cache-side line request port and the memory-side burst port of the adapter.
// The adapter takes the slave view; the arbiter/memory environment takes the master view.
interface cacheline_adapter_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
);
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, mem_rdata, mem_resp,
    output pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, mem_rdata, mem_resp,
    input  pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Turns one full-cacheline read/write request into a burst of BEAT_W-wide memory beats,
// then answers the cache side with a single-cycle pmem_resp (and the assembled line on reads).
module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) (
  input logic               clk,
  input logic               rst,
  cacheline_adapter_if.slave bus
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((LINE_W / 8) - 1);

  typedef enum logic [2:0] {IDLE, RD, WR, RESP, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] rdata_q;
  logic              last_beat;

  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // rdata_q is a separate copy so writes and half-finished reads never disturb pmem_rdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.pmem_write) begin
            addr_q <= bus.pmem_address;
            line_q <= bus.pmem_wdata;
          end else if (bus.pmem_read) begin
            addr_q <= bus.pmem_address;
          end
        end
        RD: begin
          if (bus.mem_resp) begin
            line_q[BEAT_W*cnt +: BEAT_W] <= bus.mem_rdata;
            cnt <= cnt + CNT_W'(1);
            if (last_beat) begin
              rdata_q <= {bus.mem_rdata, line_q[LINE_W-BEAT_W-1:0]};
            end
          end
        end
        WR: begin
          if (bus.mem_resp) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next     = state;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.pmem_resp  = 1'b0;
    bus.mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (bus.pmem_write) begin
          state_next = WR;
        end else if (bus.pmem_read) begin
          state_next = RD;
        end
      end
      RD: begin
        bus.mem_read = 1'b1;
        if (bus.mem_resp && last_beat) begin
          state_next = RESP;
        end
      end
      WR: begin
        bus.mem_write = 1'b1;
        bus.mem_wdata = line_q[BEAT_W*cnt +: BEAT_W];
        if (bus.mem_resp && last_beat) begin
          state_next = RESP;
        end
      end
      RESP: begin
        bus.pmem_resp = 1'b1;
        state_next    = DONE;
      end
      // Hold here until the arbiter drops its request so the same line is not fetched twice
      DONE: begin
        if (!bus.pmem_read && !bus.pmem_write) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_address = addr_q & LINE_MASK;
  assign bus.pmem_rdata  = rdata_q;
endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed vector table, a reset-mid-burst
// sequence, and randomized transactions compared against a line-level reference model.
module tb_cacheline_adapter;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cacheline_adapter_if #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) bus();

  cacheline_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One transaction: request kind, address, line (write data or memory contents),
  // memory response gap pattern (LSB first, 1 = beat offered, beyond gap_len always 1),
  // cycles to keep the request high after pmem_resp, and the expected results.
  typedef struct {
    bit          is_write;
    bit          also_read;
    logic [31:0] addr;
    logic [255:0] line;
    logic [15:0] gaps;
    int          gap_len;
    int          hold;
    logic [31:0] exp_addr;
    int          exp_lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [255:0] last_read = '0;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Negedges from the accepting edge until pmem_resp is seen: memory starts offering beats
  // one cycle after it sees the command, and the response follows the 4th accepted beat.
  function automatic int model_latency(input logic [15:0] gaps, input int gap_len);
    int ones = 0;
    for (int i = 0; i < 64; i++) begin
      if ((i < gap_len && i < 16) ? gaps[i[3:0]] : 1'b1) ones++;
      if (ones == 4) return i + 3;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    logic [63:0]  wseen [4];
    logic [255:0] rdata_at_resp = '0;
    int  beat = 0, gi = 0, cyc = 0, resp_cnt = 0, resp_cyc = -1, after = 0;
    bit  seen = 0, rd_seen = 0, wr_seen = 0, bad_addr = 0, extra_burst = 0, finished = 0;
    bit  offer;

    bus.pmem_address = v.addr;
    bus.pmem_wdata   = v.is_write ? v.line : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.pmem_write   = v.is_write;
    bus.pmem_read    = !v.is_write || v.also_read;
    bus.mem_resp     = 1'b0;

    while (!finished && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_resp) beat++;
      bus.mem_resp = 1'b0;
      if (cyc == 2) begin
        bus.pmem_address = $urandom;
        bus.pmem_wdata   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (bus.pmem_resp) begin
        resp_cnt++;
        if (resp_cyc < 0) begin
          resp_cyc      = cyc;
          rdata_at_resp = bus.pmem_rdata;
        end
      end
      if (resp_cyc >= 0) begin
        if (bus.mem_read || bus.mem_write) extra_burst = 1;
        if (after == v.hold) begin
          bus.pmem_read  = 1'b0;
          bus.pmem_write = 1'b0;
        end
        if (after == v.hold + 3) finished = 1;
        after++;
      end else if (bus.mem_read || bus.mem_write) begin
        if (bus.mem_read)  rd_seen = 1;
        if (bus.mem_write) wr_seen = 1;
        if (bus.mem_address !== v.exp_addr) bad_addr = 1;
        if (seen && beat < 4) begin
          offer = (gi < v.gap_len && gi < 16) ? v.gaps[gi[3:0]] : 1'b1;
          gi++;
          if (offer) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = v.line[64*beat +: 64];
            if (bus.mem_write) wseen[beat] = bus.mem_wdata;
          end else begin
            bus.mem_rdata = {$urandom, $urandom};
          end
        end
        seen = 1;
      end
    end
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.mem_resp   = 1'b0;

    checkOutput({tag, ".resp_count"}, 256'(resp_cnt), 256'(1));
    checkOutput({tag, ".latency"}, 256'(resp_cyc), 256'(v.exp_lat));
    checkOutput({tag, ".mem_address"}, 256'(bad_addr), 256'(0));
    checkOutput({tag, ".no_extra_burst"}, 256'(extra_burst), 256'(0));
    if (v.is_write) begin
      checkOutput({tag, ".write_burst"}, 256'({wr_seen, rd_seen}), 256'(2'b10));
      checkOutput({tag, ".wdata_beats"}, {wseen[3], wseen[2], wseen[1], wseen[0]}, v.line);
      checkOutput({tag, ".rdata_kept"}, rdata_at_resp, last_read);
    end else begin
      checkOutput({tag, ".read_burst"}, 256'({wr_seen, rd_seen}), 256'(2'b01));
      checkOutput({tag, ".rdata"}, rdata_at_resp, v.line);
      last_read = v.line;
    end
    checkOutput({tag, ".rdata_hold"}, bus.pmem_rdata, last_read);
  endtask

  vec_t vecs [5];
  vec_t rv;
  logic [63:0] b0, b1, b2;

  initial begin
    vecs[0] = '{is_write: 0, also_read: 0, addr: 32'h0000_1234,
                line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                gaps: 16'h0, gap_len: 0, hold: 0, exp_addr: 32'h0000_1220, exp_lat: 6};
    vecs[1] = '{is_write: 1, also_read: 0, addr: 32'h0000_0040,
                line: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                gaps: 16'h0, gap_len: 0, hold: 0, exp_addr: 32'h0000_0040, exp_lat: 6};
    vecs[2] = '{is_write: 0, also_read: 0, addr: 32'h0000_0080,
                line: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_1234_8765},
                gaps: 16'h0059, gap_len: 7, hold: 0, exp_addr: 32'h0000_0080, exp_lat: 9};
    vecs[3] = '{is_write: 0, also_read: 0, addr: 32'h1000_0FE0,
                line: {64'hCAFE_0003_0000_0003, 64'hCAFE_0002_0000_0002, 64'hCAFE_0001_0000_0001, 64'hCAFE_0000_0000_0000},
                gaps: 16'h0, gap_len: 0, hold: 3, exp_addr: 32'h1000_0FE0, exp_lat: 6};
    vecs[4] = '{is_write: 1, also_read: 1, addr: 32'h2000_001F,
                line: {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111, 64'hFFFF_EEEE_DDDD_CCCC, 64'hBBBB_AAAA_9999_8888},
                gaps: 16'h0, gap_len: 0, hold: 1, exp_addr: 32'h2000_0000, exp_lat: 6};

    rst = 1'b1;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.mem_rdata    = '0;
    bus.mem_resp     = 1'b0;
    #1;
    checkOutput("reset.mem_read", 256'(bus.mem_read), 256'(0));
    checkOutput("reset.mem_write", 256'(bus.mem_write), 256'(0));
    checkOutput("reset.pmem_resp", 256'(bus.pmem_resp), 256'(0));
    checkOutput("reset.mem_address", 256'(bus.mem_address), 256'(0));
    checkOutput("reset.mem_wdata", 256'(bus.mem_wdata), 256'(0));
    checkOutput("reset.pmem_rdata", bus.pmem_rdata, 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset lands after two beats of a read; the next read must restart from beat 0.
    b0 = 64'hDEAD_0000_BEEF_0000;
    b1 = 64'hDEAD_0001_BEEF_0001;
    b2 = 64'hDEAD_0002_BEEF_0002;
    bus.pmem_address = 32'h0000_0300;
    bus.pmem_read    = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b1; bus.mem_rdata = b0;
    @(negedge clk);
    bus.mem_rdata = b1;
    @(negedge clk);
    bus.mem_resp = 1'b0; bus.mem_rdata = b2;
    checkOutput("midreset.busy_before", 256'(bus.mem_read), 256'(1));
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset.mem_read", 256'(bus.mem_read), 256'(0));
    checkOutput("midreset.pmem_resp", 256'(bus.pmem_resp), 256'(0));
    checkOutput("midreset.mem_address", 256'(bus.mem_address), 256'(0));
    checkOutput("midreset.pmem_rdata", bus.pmem_rdata, 256'(0));
    last_read = '0;
    bus.pmem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rv = '{is_write: 0, also_read: 0, addr: 32'h0000_0300,
           line: {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
           gaps: 16'h0, gap_len: 0, hold: 0, exp_addr: 32'h0000_0300, exp_lat: 6};
    applyStimulus(rv, "after_reset");

    for (int i = 0; i < 20; i++) begin
      rv.is_write  = ($urandom % 2) == 1;
      rv.also_read = ($urandom % 2) == 1;
      rv.addr      = $urandom;
      rv.line      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rv.gaps      = 16'($urandom);
      rv.gap_len   = $urandom_range(0, 10);
      rv.hold      = $urandom_range(0, 3);
      rv.exp_addr  = {rv.addr[31:5], 5'b0};
      rv.exp_lat   = model_latency(rv.gaps, rv.gap_len);
      applyStimulus(rv, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
